// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and helpers for the memory-port arbiter.
// Holds the command-sequencing state enum and the requester-id width helper.
package mem_arbiter_pkg;

  // Command sequencing: accept in IDLE, drive the memory in ISSUE,
  // return read data in RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational arbitration among the request vector.
// Default build: round-robin, search starts just above last_i and wraps.
// Macro MEM_ARBITER_FIXED_PRIO_EN: fixed priority, lowest index wins,
// last_i is ignored.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [id_w(NUM_REQ)-1:0]    last_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [id_w(NUM_REQ)-1:0]    idx_o
);

  localparam int IDW = id_w(NUM_REQ);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  // Lowest set request index wins.
  always_comb begin
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
        found    = 1'b1;
      end
    end
  end
`else
  // Two passes: first requests strictly above last_i, then wrap to the
  // lowest request overall. The first hit is the round-robin winner.
  always_comb begin
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i > int'(last_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_REQ requesters onto one memory port.
// One command is accepted at a time (valid/ready), issued to the memory for
// a single cycle, and reads return data one cycle later as a one-hot pulse.
// Optional macro MEM_ARBITER_FIXED_PRIO_EN selects fixed-priority arbitration
// (lowest index wins) instead of the default round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [id_w(NUM_REQ)-1:0]      grant_id,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout
);

  localparam int IDW = id_w(NUM_REQ);

  state_e                  state_q, state_d;
  logic [IDW-1:0]          last_q;
  logic [IDW-1:0]          id_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDW-1:0]          pick_idx;
  logic                    handshake;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // The winner is a subset of req_valid, so any valid in IDLE is accepted.
  assign handshake = (state_q == IDLE) && (|(req_valid & pick_gnt));

  // Next-state and ready: ready is offered only in IDLE, to the winner.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = pick_gnt;
        if (handshake) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Arbitration history: start so that requester 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_q <= IDW'(NUM_REQ - 1);
    else if (handshake) last_q <= pick_idx;
  end

  // Command register, captured on the accepting edge; it also holds the
  // memory address/data lines steady between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (handshake) begin
      id_q    <= pick_idx;
      we_q    <= req_we[pick_idx];
      addr_q  <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Memory port and response outputs, decoded from registered state only
  // (rsp_data passes mem_dout straight through while in RESP).
  always_comb begin
    mem_we    = (state_q == ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_din   = wdata_q;
    grant_id  = id_q;
    rsp_valid = '0;
    rsp_data  = '0;
    if (state_q == RESP) begin
      rsp_valid = NUM_REQ'(1) << id_q;
      rsp_data  = mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, mem_din, mem_dout;
  logic [IDW-1:0]  grant_id;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;

  logic [DW-1:0]   mem [0:65535];

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .grant_id(grant_id),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write when enabled, registered read data.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Model state: transaction level (who owns the port until when).
  int            cyc;
  int            busy_until;
  int            m_last;
  int            m_id;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  int            issue_cyc, resp_cyc;
  logic [DW-1:0] resp_val;
  logic [DW-1:0] mmem [int];

  int            hs_ids[$];
  int            hs_cyc[$];
  logic [N-1:0]  hs_vec;
  int            rsp_cyc_seen;
  logic [DW-1:0] rsp_data_seen;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mmem.exists(int'(a))) return mmem[int'(a)];
    return init_val(a);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last     = N - 1;
    m_id       = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_din      = '0;
    issue_cyc  = -10;
    resp_cyc   = -10;
    busy_until = cyc;
  endtask

  // One cycle: called at a falling edge with inputs already applied.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    #1;
    w = -1;
    exp_rdy = '0;
    if (cyc >= busy_until) begin
      w = pick(req_valid, m_last);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("mem_we", 64'(mem_we), 64'((cyc == issue_cyc) && m_we));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_din", 64'(mem_din), 64'(m_din));
    chk("grant_id", 64'(grant_id), 64'(m_id));
    exp_rsp = '0;
    if (cyc == resp_cyc) begin
      exp_rsp[m_id] = 1'b1;
      chk("rsp_data", 64'(rsp_data), 64'(resp_val));
      rsp_cyc_seen  = cyc;
      rsp_data_seen = rsp_data;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    hs_vec = req_valid & req_ready;
    if (w >= 0) begin
      m_last    = w;
      m_id      = w;
      m_we      = req_we[w];
      m_addr    = req_addr[w*AW +: AW];
      m_din     = req_wdata[w*DW +: DW];
      issue_cyc = cyc + 1;
      if (m_we) begin
        mmem[int'(m_addr)] = m_din;
        busy_until = cyc + 2;
      end else begin
        resp_cyc   = cyc + 2;
        resp_val   = mem_val(m_addr);
        busy_until = cyc + 3;
      end
      hs_ids.push_back(w);
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Present one command from requester i and hold it until accepted.
  task automatic xact(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    set_cmd(i, we, a, d);
    req_valid[i] = 1'b1;
    do begin
      step();
      n++;
    end while (!hs_vec[i] && n < 20);
    chk("xact_accept", 64'(hs_vec[i]), 64'd1);
    req_valid[i] = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic reset_mid();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    model_reset();
  endtask

  initial begin
    int start, n, hc;
    int exp_order[5];

    for (int a = 0; a < 65536; a++) mem[a] = init_val(AW'(a));
    mem_dout     = '0;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    hs_vec       = '0;
    rsp_cyc_seen = -1;
    rsp_data_seen = '0;
    cyc          = 0;

    // Power-on reset.
    rst = 1'b1;
    #1;
    chk("por_req_ready", 64'(req_ready), 64'd0);
    chk("por_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("por_mem_we", 64'(mem_we), 64'd0);
    chk("por_mem_addr", 64'(mem_addr), 64'd0);
    chk("por_grant_id", 64'(grant_id), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // All four requesters read continuously: grant order and read spacing.
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i * 16'h0100), 8'h00);
    req_valid = '1;
    start = hs_ids.size();
    n = 0;
    while (hs_ids.size() - start < 5 && n < 40) begin
      step();
      n++;
    end
    req_valid = '0;
    chk("order_count", 64'(hs_ids.size() - start), 64'd5);
    if (hs_ids.size() - start >= 5) begin
      for (int k = 0; k < 5; k++) chk("order_id", 64'(hs_ids[start + k]), 64'(exp_order[k]));
      for (int k = 0; k < 4; k++)
        chk("read_spacing", 64'(hs_cyc[start + k + 1] - hs_cyc[start + k]), 64'd3);
    end
    repeat (3) step();

    // Requester 1 writes 0xA5 to 0x4123 and reads it back.
    xact(1, 1'b1, 16'h4123, 8'hA5);
    #1;
    chk("t1_mem_we", 64'(mem_we), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h4123);
    chk("t1_mem_din", 64'(mem_din), 64'hA5);
    step();
    rsp_cyc_seen = -1;
    xact(1, 1'b0, 16'h4123, 8'h00);
    hc = hs_cyc[$];
    step();
    step();
    chk("t1_rsp_latency", 64'(rsp_cyc_seen - hc), 64'd2);
    chk("t1_rsp_data", 64'(rsp_data_seen), 64'hA5);

    // Same low address in two banks must not alias.
    xact(0, 1'b1, 16'h0010, 8'h11);
    xact(2, 1'b1, 16'hC010, 8'h22);
    xact(0, 1'b0, 16'h0010, 8'h00);
    step();
    step();
    chk("alias_0010", 64'(rsp_data_seen), 64'h11);
    xact(2, 1'b0, 16'hC010, 8'h00);
    step();
    step();
    chk("alias_C010", 64'(rsp_data_seen), 64'h22);

    // Reset during the response phase of a read.
    rsp_cyc_seen = -1;
    xact(2, 1'b0, 16'h0300, 8'h00);
    step();
    reset_mid();
    chk("rst_no_rsp", 64'(rsp_cyc_seen), 64'hFFFF_FFFF_FFFF_FFFF);
    set_cmd(0, 1'b0, 16'h0001, 8'h00);
    set_cmd(2, 1'b0, 16'h0002, 8'h00);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    start = hs_ids.size();
    n = 0;
    while (hs_ids.size() == start && n < 10) begin
      step();
      n++;
    end
    req_valid = '0;
    chk("rst_next_grant", 64'(hs_ids[$]), 64'd0);
    repeat (3) step();

    // Requester 3 arrives while requester 0's write is issuing.
    xact(0, 1'b1, 16'h0050, 8'h33);
    set_cmd(3, 1'b1, 16'h0060, 8'h44);
    req_valid[3] = 1'b1;
    #1;
    chk("t5_ready3_issue", 64'(req_ready[3]), 64'd0);
    xact(3, 1'b1, 16'h0060, 8'h44);
    chk("t5_accept_gap", 64'(hs_cyc[$] - hs_cyc[$-1]), 64'd2);
    chk("t5_accept_id", 64'(hs_ids[$]), 64'd3);

    // Back-to-back writes from requester 1.
    set_cmd(1, 1'b1, 16'h0700, 8'h70);
    req_valid[1] = 1'b1;
    start = hs_ids.size();
    n = 0;
    while (hs_ids.size() - start < 4 && n < 30) begin
      step();
      n++;
      if (hs_vec[1]) set_cmd(1, 1'b1, AW'(16'h0700 + n), DW'(8'h70 + n));
    end
    req_valid = '0;
    chk("b2b_count", 64'(hs_ids.size() - start), 64'd4);
    if (hs_ids.size() - start >= 4)
      for (int k = 0; k < 3; k++)
        chk("b2b_spacing", 64'(hs_cyc[start + k + 1] - hs_cyc[start + k]), 64'd2);
    repeat (2) step();

    // Randomized traffic over a small address pool spanning all banks.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs_vec[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_cmd(i, 1'($urandom_range(0, 1)),
                  {2'($urandom_range(0, 3)), 10'd0, 4'($urandom_range(0, 3))},
                  8'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      step();
    end
    req_valid = '0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates among several requesters for the single port of the banked 64K x 8 composite memory. Registers one accepted command at a time onto the memory port and steps it through issue and, for reads, response return. Sits between the memory and its clients (CPU-side loader, DMA, debug port). Requesters see a valid/ready command handshake and a one-cycle read-response pulse.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 16: memory address width.
- `DATA_WIDTH`, 8: memory data width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_ready`  out  NUM_REQ  per-requester command accept.
- `req_we`  in  NUM_REQ  per-requester write (1) / read (0).
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- `rsp_valid`  out  NUM_REQ  one-hot read-response pulse.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all requesters.
- `grant_id`  out  max(1,clog2(NUM_REQ))  index of the requester owning the current command.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_din`  out  DATA_WIDTH  memory write data.
- `mem_dout`  in  DATA_WIDTH  memory read data; valid the cycle after a non-write cycle.

## Operation
- FSM states:
  - IDLE: `req_ready` is driven one-hot to the arbitration winner when any `req_valid` is set; handshake = valid & ready; on handshake go to ISSUE.
  - ISSUE: the latched command is on `mem_*` for exactly one cycle, with `mem_we` = latched `we`. After a write go to IDLE; after a read go to RESP.
  - RESP: `rsp_valid[grant_id]`=1, `rsp_data`=`mem_dout`; then go to IDLE.
- `req_ready` is 0 in ISSUE and RESP. At most one bit of `req_ready` is ever set.
- Command register: `we`, `addr`, `wdata` and the id are captured on the handshake edge.
- Round-robin arbitration: search starts at index last_grant+1 and wraps at NUM_REQ-1 to 0. last_grant updates only on a handshake.
- A requester may drop `req_valid` before it is granted. Arbitration is recomputed each cycle in IDLE.
- Outside ISSUE, `mem_we`=0. `mem_addr`/`mem_din` hold their last values.
- Reset values:
  - state IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - `req_ready`, `rsp_valid` = 0; `mem_we`=0; `mem_addr`, `mem_din`, `rsp_data`, `grant_id` = 0.
- Reset mid-operation: an in-flight write may or may not have reached the memory, depending on the edge. An in-flight read response is dropped with no `rsp_valid`.
- Address bits pass through unmodified; bank selection is the memory's job.

## Timing
- Handshake at cycle T:
  - T+1: ISSUE.
  - Write: `req_ready` can assert again at T+2.
  - Read: RESP at T+2 (`rsp_valid` for exactly 1 cycle); next accept possible at T+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `req_ready` is combinational from `req_valid` and state. No other output depends combinationally on inputs, except `rsp_data` from `mem_dout` in RESP.

## Configuration
- `MEM_ARBITER_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; last_grant is not used.
  - Undefined (default): round-robin as described above.

## Structure
- Package `mem_arbiter_pkg`: state enum (IDLE, ISSUE, RESP) and an id-width constant function.
- Sub-module `rr_pick`: combinational, takes request vector and last_grant, returns one-hot grant and index. The macro switches it to a fixed-priority encoder.

## Test plan
- Requester 1 writes 0xA5 to 0x4123 and then reads it back. Required: `mem_we` high one cycle with `mem_addr`=0x4123, and `rsp_valid[1]` with `rsp_data`=0xA5 exactly 2 cycles after the read handshake.
- All 4 requesters hold `req_valid` (reads) continuously. Required: grant order 0,1,2,3,0, no requester skipped. With the macro defined, requester 0 is granted every time.
- Requesters 0 and 2 write 0x11 to 0x0010 and 0x22 to 0xC010. Required: the readback from each address returns its own value, showing no bank aliasing.
- `rst` pulsed during RESP of a read. Required: no `rsp_valid` and all outputs 0 immediately (async). The next grant goes to requester 0.
- Requester 3 raises `req_valid` during ISSUE of requester 0's write. Required: `req_ready[3]` stays 0 until IDLE, then is accepted.
- Back-to-back writes from one requester. Required: handshakes occur every 2 cycles.
